// File: rtl/alu_pkg.sv
// Shared definitions for the multi-cycle execute unit: op codes, FSM states, op-class helpers.
package alu_pkg;

  // Codes 0..13 are the original single-cycle ALU set; 14..19 are the extensions.
  typedef enum logic [4:0] {
    OpAdd    = 5'd0,
    OpSub    = 5'd1,
    OpXor    = 5'd2,
    OpOr     = 5'd3,
    OpAnd    = 5'd4,
    OpShl    = 5'd5,
    OpShr    = 5'd6,
    OpSlt    = 5'd7,
    OpSltu   = 5'd8,
    OpAui    = 5'd9,
    OpAuipc  = 5'd10,
    OpMul    = 5'd11,
    OpDiv    = 5'd12,
    OpRem    = 5'd13,
    OpShra   = 5'd14,
    OpMulh   = 5'd15,
    OpMulhsu = 5'd16,
    OpMulhu  = 5'd17,
    OpDivu   = 5'd18,
    OpRemu   = 5'd19
  } alu_op_e;

  typedef enum logic [1:0] {
    StIdle,
    StBusy,
    StDone
  } alu_state_e;

  function automatic logic is_mul(input logic [4:0] op);
    return op inside {OpMul, OpMulh, OpMulhsu, OpMulhu};
  endfunction

  function automatic logic is_div(input logic [4:0] op);
    return op inside {OpDiv, OpRem, OpDivu, OpRemu};
  endfunction

  function automatic logic is_muldiv(input logic [4:0] op);
    return is_mul(op) || is_div(op);
  endfunction

endpackage

// File: rtl/alu_mc_if.sv
// Request/response bundle between the issue stage (master) and the execute unit (slave).
interface alu_mc_if #(
  parameter int unsigned XLEN = 32
) ();
  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic [4:0]      op;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;

  modport master (
    output flush, in_valid, op, pc, a, b, out_ready,
    input  in_ready, out_valid, result
  );

  modport slave (
    input  flush, in_valid, op, pc, a, b, out_ready,
    output in_ready, out_valid, result
  );
endinterface

// File: rtl/iter_muldiv.sv
// Radix-2 iterative engine: shift-add multiplier / restoring divider on unsigned magnitudes.
// One bit per cycle; on the final cycle the outputs carry the completed (unregistered) step.
module iter_muldiv #(
  parameter int unsigned XLEN = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush_i,
  input  logic              start_i,
  input  logic              mul_ndiv_i,
  input  logic [XLEN-1:0]   a_mag_i,
  input  logic [XLEN-1:0]   b_mag_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [2*XLEN-1:0] prod_o,
  output logic [XLEN-1:0]   quot_o,
  output logic [XLEN-1:0]   rem_o
);
  localparam int unsigned SHW = $clog2(XLEN);
  localparam logic [SHW-1:0] LastCnt = SHW'(XLEN - 1);

  logic            busy_q, busy_d;
  logic            mul_q, mul_d;
  logic [SHW-1:0]  cnt_q, cnt_d;
  // acc: product high half / partial remainder; lo: multiplier / quotient; opd: mcand / divisor
  logic [XLEN-1:0] acc_q, acc_d, lo_q, lo_d, opd_q, opd_d;
  logic [XLEN-1:0] step_acc, step_lo;
  logic [XLEN:0]   sum, rem_tmp, diff;
  logic            ge;

  // One iteration of either algorithm from the current registers
  always_comb begin
    sum     = {1'b0, acc_q} + (lo_q[0] ? {1'b0, opd_q} : '0);
    rem_tmp = {acc_q, lo_q[XLEN-1]};
    diff    = rem_tmp - {1'b0, opd_q};
    // partial remainder < divisor, so the borrow bit alone decides the trial subtract
    ge      = ~diff[XLEN];
    if (mul_q) begin
      step_acc = sum[XLEN:1];
      step_lo  = {sum[0], lo_q[XLEN-1:1]};
    end else begin
      step_acc = ge ? diff[XLEN-1:0] : rem_tmp[XLEN-1:0];
      step_lo  = {lo_q[XLEN-2:0], ge};
    end
  end

  // Load on start, iterate while busy, abort on flush
  always_comb begin
    busy_d = busy_q;
    mul_d  = mul_q;
    cnt_d  = cnt_q;
    acc_d  = acc_q;
    lo_d   = lo_q;
    opd_d  = opd_q;
    if (flush_i) begin
      busy_d = 1'b0;
    end else if (start_i) begin
      busy_d = 1'b1;
      mul_d  = mul_ndiv_i;
      cnt_d  = '0;
      acc_d  = '0;
      lo_d   = a_mag_i;
      opd_d  = b_mag_i;
    end else if (busy_q) begin
      acc_d = step_acc;
      lo_d  = step_lo;
      cnt_d = cnt_q + {{(SHW-1){1'b0}}, 1'b1};
      if (done_o) busy_d = 1'b0;
    end
  end

  // Engine state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= 1'b0;
      mul_q  <= 1'b0;
      cnt_q  <= '0;
      acc_q  <= '0;
      lo_q   <= '0;
      opd_q  <= '0;
    end else begin
      busy_q <= busy_d;
      mul_q  <= mul_d;
      cnt_q  <= cnt_d;
      acc_q  <= acc_d;
      lo_q   <= lo_d;
      opd_q  <= opd_d;
    end
  end

  assign busy_o = busy_q;
  assign done_o = busy_q && (cnt_q == LastCnt);
  assign prod_o = {step_acc, step_lo};
  assign quot_o = step_lo;
  assign rem_o  = step_acc;

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle execute unit: valid/ready in, registered result out, iterative MUL/DIV family.
module alu_mc
  import alu_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input logic     clk,
  input logic     rst_n,
  alu_mc_if.slave bus_io
);
  localparam int unsigned SHW = $clog2(XLEN);
  localparam logic [XLEN-1:0] MinNeg = {1'b1, {(XLEN-1){1'b0}}};

  alu_state_e      state_q, state_d;
  logic [4:0]      op_q;
  logic            neg_q;
  logic [XLEN-1:0] result_q, result_d;

  logic [4:0]      op_in;
  logic [XLEN-1:0] a_in, b_in, pc_in;
  logic [SHW-1:0]  shamt;
  logic            accept, start, special, b_zero, ovf;
  logic            neg_a, neg_b, neg_in;
  logic [XLEN-1:0] a_mag, b_mag, simple_res, md_res;
  logic            md_busy, md_done;
  logic [2*XLEN-1:0] md_prod, prod_fix;
  logic [XLEN-1:0] md_quot, md_rem;
  logic            in_ready, out_valid;

  assign op_in  = bus_io.op;
  assign a_in   = bus_io.a;
  assign b_in   = bus_io.b;
  assign pc_in  = bus_io.pc;
  assign shamt  = b_in[SHW-1:0];
  // flush wins over a same-cycle request
  assign accept = bus_io.in_valid && in_ready && !bus_io.flush;
  assign start  = accept && is_muldiv(op_in) && !special;

  // Operand decode: divide special cases and signed magnitudes for the engine
  always_comb begin
    b_zero  = (b_in == '0);
    ovf     = (op_in inside {OpDiv, OpRem}) && (a_in == MinNeg) && (b_in == '1);
    special = is_div(op_in) && (b_zero || ovf);
    neg_a   = (op_in inside {OpMul, OpMulh, OpMulhsu, OpDiv, OpRem}) && a_in[XLEN-1];
    neg_b   = (op_in inside {OpMul, OpMulh, OpDiv, OpRem}) && b_in[XLEN-1];
    a_mag   = neg_a ? -a_in : a_in;
    b_mag   = neg_b ? -b_in : b_in;
    // remainder takes the dividend's sign; products and quotients the xor of both
    neg_in  = (op_in == OpRem) ? neg_a : (neg_a ^ neg_b);
  end

  // Single-cycle results, including the divide-by-zero / overflow shortcuts
  always_comb begin
    simple_res = '0;
    case (op_in)
      OpAdd:          simple_res = a_in + b_in;
      OpSub:          simple_res = a_in - b_in;
      OpXor:          simple_res = a_in ^ b_in;
      OpOr:           simple_res = a_in | b_in;
      OpAnd:          simple_res = a_in & b_in;
      OpShl:          simple_res = a_in << shamt;
      OpShr:          simple_res = a_in >> shamt;
      OpShra:         simple_res = $unsigned($signed(a_in) >>> shamt);
      OpSlt:          simple_res = {{(XLEN-1){1'b0}}, $signed(a_in) < $signed(b_in)};
      OpSltu:         simple_res = {{(XLEN-1){1'b0}}, a_in < b_in};
      OpAui:          simple_res = b_in << 12;
      OpAuipc:        simple_res = pc_in + (b_in << 12);
      OpDiv, OpDivu:  simple_res = b_zero ? '1 : a_in;
      OpRem, OpRemu:  simple_res = b_zero ? a_in : '0;
      default:        simple_res = '0;
    endcase
  end

  iter_muldiv #(
    .XLEN (XLEN)
  ) u_muldiv (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush_i    (bus_io.flush),
    .start_i    (start),
    .mul_ndiv_i (is_mul(op_in)),
    .a_mag_i    (a_mag),
    .b_mag_i    (b_mag),
    .busy_o     (md_busy),
    .done_o     (md_done),
    .prod_o     (md_prod),
    .quot_o     (md_quot),
    .rem_o      (md_rem)
  );

  // Sign fixup and half select of the engine result on the DONE-entry cycle
  always_comb begin
    prod_fix = neg_q ? -md_prod : md_prod;
    case (op_q)
      OpMul:                     md_res = prod_fix[XLEN-1:0];
      OpMulh, OpMulhsu, OpMulhu: md_res = prod_fix[2*XLEN-1:XLEN];
      OpDiv, OpDivu:             md_res = neg_q ? -md_quot : md_quot;
      default:                   md_res = neg_q ? -md_rem : md_rem;
    endcase
  end

  // Next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: if (accept) state_d = start ? StBusy : StDone;
      StBusy: begin
        if (bus_io.flush)            state_d = StIdle;
        else if (md_busy && md_done) state_d = StDone;
      end
      StDone: if (bus_io.flush || bus_io.out_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Handshake outputs
  always_comb begin
    in_ready  = (state_q == StIdle);
    out_valid = (state_q == StDone);
  end

  // Result only moves on the edge that enters DONE
  always_comb begin
    result_d = result_q;
    if (accept && !start) begin
      result_d = simple_res;
    end else if (state_q == StBusy && md_busy && md_done && !bus_io.flush) begin
      result_d = md_res;
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= StIdle;
    else        state_q <= state_d;
  end

  // Result and op/sign latches
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_q <= '0;
      op_q     <= '0;
      neg_q    <= 1'b0;
    end else begin
      result_q <= result_d;
      if (accept) begin
        op_q  <= op_in;
        neg_q <= neg_in;
      end
    end
  end

  assign bus_io.in_ready  = in_ready;
  assign bus_io.out_valid = out_valid;
  assign bus_io.result    = result_q;

endmodule

// File: tb/tb_alu_mc.sv
// Self-checking bench for alu_mc: directed corner vectors, random ops vs. an arithmetic model,
// reset, backpressure and flush scenarios.
module tb_alu_mc;
  import alu_pkg::*;

  localparam int unsigned XLEN = 32;
  localparam logic [31:0] MinNeg = 32'h8000_0000;

  logic clk = 1'b0;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  alu_mc_if #(.XLEN(XLEN)) bus ();

  alu_mc #(
    .XLEN (XLEN)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus_io (bus)
  );

  typedef struct packed {
    logic [4:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] pc;
    logic [31:0] exp;
    logic [7:0]  lat;
  } vec_t;

  // Architectural reference computed with 64-bit integer arithmetic
  function automatic logic [31:0] ref_result(input logic [4:0] op, input logic [31:0] a,
                                             input logic [31:0] b, input logic [31:0] pc);
    longint sa, sb, ua, ub;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'h0, a};
    ub = {32'h0, b};
    case (op)
      OpAdd:    return a + b;
      OpSub:    return a - b;
      OpXor:    return a ^ b;
      OpOr:     return a | b;
      OpAnd:    return a & b;
      OpShl:    return a << b[4:0];
      OpShr:    return a >> b[4:0];
      OpShra:   begin p = sa >>> b[4:0]; return p[31:0]; end
      OpSlt:    return (sa < sb) ? 32'd1 : 32'd0;
      OpSltu:   return (ua < ub) ? 32'd1 : 32'd0;
      OpAui:    return b * 32'd4096;
      OpAuipc:  return pc + b * 32'd4096;
      OpMul:    begin p = sa * sb; return p[31:0]; end
      OpMulh:   begin p = sa * sb; return p[63:32]; end
      OpMulhsu: begin p = sa * ub; return p[63:32]; end
      OpMulhu:  begin p = ua * ub; return p[63:32]; end
      OpDiv:    begin if (b == 0) return '1; p = sa / sb; return p[31:0]; end
      OpRem:    begin if (b == 0) return a;  p = sa % sb; return p[31:0]; end
      OpDivu:   begin if (b == 0) return '1; p = ua / ub; return p[31:0]; end
      OpRemu:   begin if (b == 0) return a;  p = ua % ub; return p[31:0]; end
      default:  return 32'd0;
    endcase
  endfunction

  function automatic int ref_latency(input logic [4:0] op, input logic [31:0] a,
                                     input logic [31:0] b);
    if (op inside {OpDiv, OpRem, OpDivu, OpRemu}) begin
      if (b == 0) return 1;
      if ((op inside {OpDiv, OpRem}) && a == MinNeg && b == 32'hFFFF_FFFF) return 1;
      return XLEN + 1;
    end
    if (op inside {OpMul, OpMulh, OpMulhsu, OpMulhu}) return XLEN + 1;
    return 1;
  endfunction

  // Issue one op, count edges from accept to out_valid (-1 on timeout), then retire it
  task automatic run_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] pc, output logic [31:0] res, output int lat);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.op = op;
    bus.a  = a;
    bus.b  = b;
    bus.pc = pc;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.op = 5'($urandom());
    bus.a  = $urandom();
    bus.b  = $urandom();
    bus.pc = $urandom();
    lat = 1;
    while (!bus.out_valid && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    if (!bus.out_valid) lat = -1;
    res = bus.result;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid);
    end
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready);
    end
    checks++;
    if (bus.result !== 32'd0) begin
      errors++; $display("FAIL reset_result: got %h want 0", bus.result);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL post_reset_idle: out_valid=%b in_ready=%b want 0/1", bus.out_valid,
               bus.in_ready);
    end
  endtask

  task automatic test_directed();
    vec_t v [16] = '{
      '{OpAdd,    32'hFFFF_FFFF, 32'h1,         32'h0,    32'h0,         8'd1},
      '{OpShra,   32'h8000_0000, 32'd33,        32'h0,    32'hC000_0000, 8'd1},
      '{OpSlt,    32'hFFFF_FFFF, 32'h1,         32'h0,    32'h1,         8'd1},
      '{OpSltu,   32'hFFFF_FFFF, 32'h1,         32'h0,    32'h0,         8'd1},
      '{OpMulh,   32'h8000_0000, 32'h8000_0000, 32'h0,    32'h4000_0000, 8'd33},
      '{OpMulhu,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0,    32'hFFFF_FFFE, 8'd33},
      '{OpMul,    32'd7,         32'hFFFF_FFFD, 32'h0,    32'hFFFF_FFEB, 8'd33},
      '{OpDiv,    32'hFFFF_FFF9, 32'd2,         32'h0,    32'hFFFF_FFFD, 8'd33},
      '{OpRem,    32'hFFFF_FFF9, 32'd2,         32'h0,    32'hFFFF_FFFF, 8'd33},
      '{OpDivu,   32'd5,         32'd0,         32'h0,    32'hFFFF_FFFF, 8'd1},
      '{OpDiv,    32'h8000_0000, 32'hFFFF_FFFF, 32'h0,    32'h8000_0000, 8'd1},
      '{OpRem,    32'h8000_0000, 32'hFFFF_FFFF, 32'h0,    32'h0,         8'd1},
      '{OpRemu,   32'd9,         32'd0,         32'h0,    32'd9,         8'd1},
      '{OpAuipc,  32'h0,         32'h12345,     32'h1000, 32'h1234_6000, 8'd1},
      '{OpMulhsu, 32'hFFFF_FFFF, 32'd2,         32'h0,    32'hFFFF_FFFF, 8'd33},
      '{5'd31,    32'h1234_5678, 32'h9,         32'h0,    32'h0,         8'd1}
    };
    logic [31:0] res;
    int lat;
    for (int i = 0; i < 16; i++) begin
      run_op(v[i].op, v[i].a, v[i].b, v[i].pc, res, lat);
      checks++;
      if (res !== v[i].exp) begin
        errors++;
        $display("FAIL directed_result[%0d] op=%0d: got %h want %h", i, v[i].op, res, v[i].exp);
      end
      checks++;
      if (lat != int'(v[i].lat)) begin
        errors++;
        $display("FAIL directed_latency[%0d] op=%0d: got %0d want %0d", i, v[i].op, lat,
                 v[i].lat);
      end
    end
  endtask

  task automatic test_random();
    logic [4:0]  op;
    logic [31:0] a, b, pc, res, exp;
    int lat, exp_lat;
    for (int i = 0; i < 60; i++) begin
      op = 5'($urandom_range(0, 21));
      a  = $urandom();
      b  = $urandom();
      pc = $urandom();
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: b = 32'hFFFF_FFFF;
        2: begin a = MinNeg; b = 32'hFFFF_FFFF; end
        3: b = 32'($urandom_range(1, 15));
        default: ;
      endcase
      exp     = ref_result(op, a, b, pc);
      exp_lat = ref_latency(op, a, b);
      run_op(op, a, b, pc, res, lat);
      checks++;
      if (res !== exp) begin
        errors++;
        $display("FAIL random_result[%0d] op=%0d a=%h b=%h: got %h want %h", i, op, a, b, res,
                 exp);
      end
      checks++;
      if (lat != exp_lat) begin
        errors++;
        $display("FAIL random_latency[%0d] op=%0d: got %0d want %0d", i, op, lat, exp_lat);
      end
    end
  endtask

  task automatic test_reset_busy();
    logic [31:0] res;
    int lat;
    bit seen;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.op = OpDiv;
    bus.a  = 32'd100;
    bus.b  = 32'd7;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_busy_handshake: out_valid=%b in_ready=%b want 0/1", bus.out_valid,
               bus.in_ready);
    end
    checks++;
    if (bus.result !== 32'd0) begin
      errors++; $display("FAIL reset_busy_result: got %h want 0", bus.result);
    end
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (bus.out_valid) seen = 1'b1;
    end
    checks++;
    if (seen) begin
      errors++; $display("FAIL reset_busy_stale: out_valid rose after reset, want never");
    end
    run_op(OpAdd, 32'd3, 32'd4, 32'd0, res, lat);
    checks++;
    if (res !== 32'd7 || lat != 1) begin
      errors++; $display("FAIL reset_busy_next: got %h lat %0d want 7 lat 1", res, lat);
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] exp;
    exp = 32'h0000_F0F0 ^ 32'h0000_0FF0;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.op = OpXor;
    bus.a  = 32'h0000_F0F0;
    bus.b  = 32'h0000_0FF0;
    @(posedge clk);
    #1;
    bus.op = OpAdd;
    bus.a  = 32'd1;
    bus.b  = 32'd1;
    checks++;
    if (bus.out_valid !== 1'b1 || bus.result !== exp) begin
      errors++;
      $display("FAIL bp_first: out_valid=%b result=%h want 1/%h", bus.out_valid, bus.result,
               exp);
    end
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      checks++;
      if (bus.out_valid !== 1'b1 || bus.result !== exp) begin
        errors++;
        $display("FAIL bp_hold[%0d]: out_valid=%b result=%h want 1/%h", i, bus.out_valid,
                 bus.result, exp);
      end
      checks++;
      if (bus.in_ready !== 1'b0) begin
        errors++; $display("FAIL bp_in_ready[%0d]: got %b want 0", i, bus.in_ready);
      end
    end
    @(negedge clk);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1 bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
        errors++;
        $display("FAIL bp_no_accept[%0d]: out_valid=%b in_ready=%b want 0/1", i, bus.out_valid,
                 bus.in_ready);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_flush();
    logic [31:0] res;
    int lat;
    bit seen;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.op = OpMul;
    bus.a  = 32'd123;
    bus.b  = 32'd456;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    bus.flush = 1'b1;
    @(posedge clk);
    #1 bus.flush = 1'b0;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL flush_busy: out_valid=%b in_ready=%b want 0/1", bus.out_valid,
               bus.in_ready);
    end
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (bus.out_valid) seen = 1'b1;
    end
    checks++;
    if (seen) begin
      errors++; $display("FAIL flush_busy_valid: out_valid rose after flush, want never");
    end
    @(negedge clk);
    bus.flush    = 1'b1;
    bus.in_valid = 1'b1;
    bus.op = OpAdd;
    bus.a  = 32'd1;
    bus.b  = 32'd2;
    @(posedge clk);
    #1;
    bus.flush    = 1'b0;
    bus.in_valid = 1'b0;
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++; $display("FAIL flush_accept_ready: got %b want 1", bus.in_ready);
    end
    seen = 1'b0;
    if (bus.out_valid) seen = 1'b1;
    repeat (5) begin
      @(posedge clk);
      #1;
      if (bus.out_valid) seen = 1'b1;
    end
    checks++;
    if (seen) begin
      errors++; $display("FAIL flush_accept_valid: out_valid rose, want never");
    end
    run_op(OpMul, 32'd123, 32'd456, 32'd0, res, lat);
    checks++;
    if (res !== 32'd56088 || lat != 33) begin
      errors++; $display("FAIL flush_next: got %h lat %0d want %h lat 33", res, lat, 32'd56088);
    end
  endtask

  initial begin
    bus.flush     = 1'b0;
    bus.in_valid  = 1'b0;
    bus.op        = '0;
    bus.pc        = '0;
    bus.a         = '0;
    bus.b         = '0;
    bus.out_ready = 1'b0;
    test_reset();
    test_directed();
    test_random();
    test_backpressure();
    test_flush();
    test_reset_busy();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
